// File: rtl/stdp_pkg.sv
// Shared defaults and small arithmetic helpers for the STDP LIF array.
package stdp_pkg;

    localparam int unsigned N_PRE_DEF      = 2;
    localparam int unsigned V_W_DEF        = 8;
    localparam int unsigned W_W_DEF        = 4;
    localparam int unsigned BETA_SHIFT_DEF = 2;
    localparam int unsigned THRESH_DEF     = 200;
    localparam int unsigned REFRAC_DEF     = 2;
    localparam int unsigned WINDOW_DEF     = 7;
    localparam int unsigned W_INIT_DEF     = 8;
    localparam int unsigned W_SHIFT_DEF    = 4;

    function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                            input int unsigned limit);
        return (a + b > limit) ? limit : a + b;
    endfunction

    function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
        return (a > b) ? a - b : 0;
    endfunction

    function automatic int unsigned clog2(input int unsigned x);
        return $clog2(x);
    endfunction

endpackage

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: shift-based leak, saturating integration,
// registered one-cycle spike and a refractory hold after each spike.
module lif_neuron
    import stdp_pkg::*;
#(
    parameter int unsigned V_W        = V_W_DEF,
    parameter int unsigned BETA_SHIFT = BETA_SHIFT_DEF,
    parameter int unsigned THRESH     = THRESH_DEF,
    parameter int unsigned REFRAC     = REFRAC_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [V_W-1:0] current,
    output logic           spike,
    output logic [V_W-1:0] v
);
    localparam int unsigned RW = clog2(REFRAC + 2);

    logic [V_W-1:0] v_q, v_d, leaked, sum;
    logic [V_W:0]   sum_w;
    logic [RW-1:0]  refrac_q, refrac_d;
    logic           spike_q, spike_d;

    always_comb begin
        leaked   = v_q - (v_q >> BETA_SHIFT);
        sum_w    = {1'b0, leaked} + {1'b0, current};
        sum      = sum_w[V_W] ? '1 : sum_w[V_W-1:0];
        v_d      = v_q;
        spike_d  = spike_q;
        refrac_d = refrac_q;
        if (en) begin
            if (refrac_q != '0) begin
                v_d      = '0;
                spike_d  = 1'b0;
                refrac_d = refrac_q - RW'(1);
            end else if (32'(sum) >= THRESH) begin
                v_d      = '0;
                spike_d  = 1'b1;
                refrac_d = RW'(REFRAC);
            end else begin
                v_d     = sum;
                spike_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q      <= '0;
            spike_q  <= 1'b0;
            refrac_q <= '0;
        end else begin
            v_q      <= v_d;
            spike_q  <= spike_d;
            refrac_q <= refrac_d;
        end
    end

    assign spike = spike_q;
    assign v     = v_q;

endmodule

// File: rtl/stdp_lif_array.sv
// N_PRE presynaptic LIF neurons drive one postsynaptic LIF neuron through weights
// that are learned with pair-based, trace-windowed STDP.
module stdp_lif_array
    import stdp_pkg::*;
#(
    parameter int unsigned N_PRE      = N_PRE_DEF,
    parameter int unsigned V_W        = V_W_DEF,
    parameter int unsigned W_W        = W_W_DEF,
    parameter int unsigned BETA_SHIFT = BETA_SHIFT_DEF,
    parameter int unsigned THRESH     = THRESH_DEF,
    parameter int unsigned REFRAC     = REFRAC_DEF,
    parameter int unsigned WINDOW     = WINDOW_DEF,
    parameter int unsigned W_INIT     = W_INIT_DEF,
    parameter int unsigned W_SHIFT    = W_SHIFT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 learn_en,
    input  logic [N_PRE*V_W-1:0] pre_current,
    output logic [N_PRE-1:0]     pre_spike,
    output logic                 post_spike,
    output logic [V_W-1:0]       post_state,
    output logic [N_PRE*W_W-1:0] weight_out
);
    localparam int unsigned SW   = V_W + clog2(N_PRE) + 1;
    localparam int unsigned TW   = clog2(WINDOW + 2);
    localparam int unsigned WMAX = (1 << W_W) - 1;
    localparam logic [SW-1:0] VMAX = SW'((1 << V_W) - 1);

    logic [N_PRE-1:0][V_W-1:0] pre_v;
    logic [N_PRE-1:0][W_W-1:0] weight_q, weight_d;
    logic [N_PRE-1:0][TW-1:0]  pre_tr_q, pre_tr_d;
    logic [TW-1:0]             post_tr_q, post_tr_d;
    logic [SW-1:0]             i_sum;
    logic [V_W-1:0]            i_post;
    logic                      unused_pre_v;

    for (genvar i = 0; i < N_PRE; i++) begin : g_pre
        lif_neuron #(
            .V_W       (V_W),
            .BETA_SHIFT(BETA_SHIFT),
            .THRESH    (THRESH),
            .REFRAC    (REFRAC)
        ) u_pre (
            .clk    (clk),
            .rst    (rst),
            .en     (en),
            .current(pre_current[i*V_W +: V_W]),
            .spike  (pre_spike[i]),
            .v      (pre_v[i])
        );
    end

    // Pre membrane potentials are internal only.
    assign unused_pre_v = ^pre_v;

    // Synaptic input comes from the registered pre spikes: one cycle of delay.
    always_comb begin
        i_sum = '0;
        for (int i = 0; i < N_PRE; i++) begin
            if (pre_spike[i]) begin
                i_sum = i_sum + (SW'(weight_q[i]) << W_SHIFT);
            end
        end
        i_post = (i_sum > VMAX) ? '1 : i_sum[V_W-1:0];
    end

    lif_neuron #(
        .V_W       (V_W),
        .BETA_SHIFT(BETA_SHIFT),
        .THRESH    (THRESH),
        .REFRAC    (REFRAC)
    ) u_post (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .current(i_post),
        .spike  (post_spike),
        .v      (post_state)
    );

    // Learning reads spikes and traces as they stand before this edge's update.
    always_comb begin
        pre_tr_d  = pre_tr_q;
        post_tr_d = post_tr_q;
        weight_d  = weight_q;
        if (en) begin
            post_tr_d = post_spike ? TW'(WINDOW) : TW'(sat_sub(32'(post_tr_q), 1));
            for (int i = 0; i < N_PRE; i++) begin
                pre_tr_d[i] = pre_spike[i] ? TW'(WINDOW) : TW'(sat_sub(32'(pre_tr_q[i]), 1));
                if (learn_en) begin
                    if (post_spike && pre_tr_q[i] != '0 && !pre_spike[i]) begin
                        weight_d[i] = W_W'(sat_add(32'(weight_q[i]), 1, WMAX));
                    end else if (pre_spike[i] && post_tr_q != '0 && !post_spike) begin
                        weight_d[i] = W_W'(sat_sub(32'(weight_q[i]), 1));
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_PRE; i++) begin
                weight_q[i] <= W_W'(W_INIT);
            end
            pre_tr_q  <= '0;
            post_tr_q <= '0;
        end else begin
            weight_q  <= weight_d;
            pre_tr_q  <= pre_tr_d;
            post_tr_q <= post_tr_d;
        end
    end

    assign weight_out = weight_q;

endmodule

// File: tb/tb_stdp_lif_array.sv
// Bench for stdp_lif_array: directed scenarios plus randomized traffic, all checked
// against an integer reference model of the neurons, traces and learning rule.
module tb_stdp_lif_array;
    localparam int N  = 2;
    localparam int VW = 8;
    localparam int WW = 4;
    localparam int P  = N;  // model index of the post neuron
    localparam int OW = N*WW + VW + 1 + N;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              learn_en = 1'b0;
    logic [N*VW-1:0]   pre_current = '0;
    logic [N-1:0]      pre_spike;
    logic              post_spike;
    logic [VW-1:0]     post_state;
    logic [N*WW-1:0]   weight_out;
    logic [OW-1:0]     dut_obs;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int cur[N];
    int m_v[N+1], m_ref[N+1], m_spk[N+1], m_tr[N+1], m_w[N];

    stdp_lif_array dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .learn_en   (learn_en),
        .pre_current(pre_current),
        .pre_spike  (pre_spike),
        .post_spike (post_spike),
        .post_state (post_state),
        .weight_out (weight_out)
    );

    always #5 clk = ~clk;

    assign dut_obs = {weight_out, post_state, post_spike, pre_spike};

    task automatic model_step(input bit r, input bit e, input bit l);
        int nv[N+1], nref[N+1], nspk[N+1], ntr[N+1], nw[N];
        int ipost, drive, sum;
        if (r) begin
            for (int k = 0; k <= N; k++) begin
                m_v[k] = 0; m_ref[k] = 0; m_spk[k] = 0; m_tr[k] = 0;
            end
            for (int i = 0; i < N; i++) m_w[i] = 8;
            return;
        end
        if (!e) return;
        ipost = 0;
        for (int i = 0; i < N; i++) if (m_spk[i] != 0) ipost += m_w[i] * 16;
        if (ipost > 255) ipost = 255;
        for (int k = 0; k <= N; k++) begin
            drive = (k < N) ? cur[k] : ipost;
            if (m_ref[k] > 0) begin
                nv[k] = 0; nref[k] = m_ref[k] - 1; nspk[k] = 0;
            end else begin
                sum = m_v[k] - m_v[k] / 4 + drive;
                if (sum > 255) sum = 255;
                if (sum >= 200) begin
                    nv[k] = 0; nref[k] = 2; nspk[k] = 1;
                end else begin
                    nv[k] = sum; nref[k] = 0; nspk[k] = 0;
                end
            end
            ntr[k] = (m_spk[k] != 0) ? 7 : ((m_tr[k] > 0) ? m_tr[k] - 1 : 0);
        end
        for (int i = 0; i < N; i++) begin
            nw[i] = m_w[i];
            if (l) begin
                if (m_spk[P] != 0 && m_tr[i] > 0 && m_spk[i] == 0)
                    nw[i] = (m_w[i] < 15) ? m_w[i] + 1 : 15;
                else if (m_spk[i] != 0 && m_tr[P] > 0 && m_spk[P] == 0)
                    nw[i] = (m_w[i] > 0) ? m_w[i] - 1 : 0;
            end
        end
        for (int k = 0; k <= N; k++) begin
            m_v[k] = nv[k]; m_ref[k] = nref[k]; m_spk[k] = nspk[k]; m_tr[k] = ntr[k];
        end
        for (int i = 0; i < N; i++) m_w[i] = nw[i];
    endtask

    function automatic logic [OW-1:0] model_obs();
        logic [OW-1:0] o;
        o = '0;
        for (int i = 0; i < N; i++) o[i] = (m_spk[i] != 0);
        o[N] = (m_spk[P] != 0);
        o[N+1 +: VW] = VW'(m_v[P]);
        for (int i = 0; i < N; i++) o[N+1+VW+WW*i +: WW] = WW'(m_w[i]);
        return o;
    endfunction

    task automatic step(input bit r, input bit e, input bit l);
        rst = r; en = e; learn_en = l;
        for (int i = 0; i < N; i++) pre_current[i*VW +: VW] = VW'(cur[i]);
        @(posedge clk);
        model_step(r, e, l);
        #1;
        cyc++;
    endtask

    // Holds learn_en low until the model state makes the chosen learning case apply.
    task automatic seek(input int mode, output bit found);
        bit gate;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            case (mode)
                0:       gate = m_spk[0] != 0 && m_spk[P] == 0 && m_tr[P] > 0;
                1:       gate = m_spk[P] != 0 && m_spk[0] == 0 && m_tr[0] > 0;
                default: gate = m_spk[0] != 0 && m_spk[P] != 0;
            endcase
            step(1'b0, 1'b1, gate);
            found = gate;
        end
    endtask

    task automatic test_reset();
        cur[0] = 100; cur[1] = 100;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        n_checks++;
        if (weight_out !== 8'h88) begin
            n_fail++; $display("FAIL reset_weights: got %h expected 88", weight_out);
        end
        n_checks++;
        if (pre_spike !== 2'b00) begin
            n_fail++; $display("FAIL reset_pre_spike: got %b expected 00", pre_spike);
        end
        n_checks++;
        if (post_spike !== 1'b0) begin
            n_fail++; $display("FAIL reset_post_spike: got %b expected 0", post_spike);
        end
        n_checks++;
        if (post_state !== 8'h00) begin
            n_fail++; $display("FAIL reset_post_state: got %0d expected 0", post_state);
        end
    endtask

    task automatic test_charge();
        cur[0] = 64; cur[1] = 0;
        for (int k = 1; k <= 14; k++) begin
            step(1'b0, 1'b1, 1'b1);
            n_checks++;
            if (pre_spike[0] !== (k == 6 || k == 14)) begin
                n_fail++;
                $display("FAIL charge_spike edge %0d: got %b expected %b", k, pre_spike[0],
                         (k == 6 || k == 14));
            end
            n_checks++;
            if (dut_obs !== model_obs()) begin
                n_fail++;
                $display("FAIL charge_model edge %0d: got %h expected %h", k, dut_obs, model_obs());
            end
        end
    endtask

    task automatic test_saturation();
        step(1'b1, 1'b0, 1'b0);
        cur[0] = 255; cur[1] = 0;
        for (int k = 1; k <= 12; k++) begin
            step(1'b0, 1'b1, 1'b1);
            n_checks++;
            if (pre_spike[0] !== (k % 3 == 1)) begin
                n_fail++;
                $display("FAIL saturate_spike edge %0d: got %b expected %b", k, pre_spike[0],
                         (k % 3 == 1));
            end
            n_checks++;
            if (dut_obs !== model_obs()) begin
                n_fail++;
                $display("FAIL saturate_model edge %0d: got %h expected %h", k, dut_obs, model_obs());
            end
        end
    endtask

    task automatic test_coincident_drive();
        step(1'b1, 1'b0, 1'b0);
        cur[0] = 255; cur[1] = 255;
        step(1'b0, 1'b1, 1'b1);
        n_checks++;
        if (pre_spike !== 2'b11) begin
            n_fail++; $display("FAIL drive_pre: got %b expected 11", pre_spike);
        end
        cur[0] = 0; cur[1] = 0;
        step(1'b0, 1'b1, 1'b1);
        n_checks++;
        if (post_spike !== 1'b1) begin
            n_fail++; $display("FAIL drive_post: got %b expected 1", post_spike);
        end
        step(1'b0, 1'b1, 1'b1);
        n_checks++;
        if (weight_out !== 8'h99) begin
            n_fail++; $display("FAIL drive_potentiate: got %h expected 99", weight_out);
        end
        n_checks++;
        if (dut_obs !== model_obs()) begin
            n_fail++; $display("FAIL drive_model: got %h expected %h", dut_obs, model_obs());
        end
    endtask

    task automatic test_depress_floor();
        bit found;
        int exp_w = 8;
        step(1'b1, 1'b0, 1'b0);
        cur[0] = 255; cur[1] = 0;
        step(1'b0, 1'b1, 1'b0);
        cur[1] = 255;  // pre1 fires one edge behind pre0
        for (int n = 0; n < 10; n++) begin
            seek(0, found);
            n_checks++;
            if (!found) begin
                n_fail++; $display("FAIL depress_timeout round %0d: got none expected gate", n);
            end
            exp_w = (exp_w > 0) ? exp_w - 1 : 0;
            n_checks++;
            if (weight_out[3:0] !== 4'(exp_w)) begin
                n_fail++;
                $display("FAIL depress_w0 round %0d: got %0d expected %0d", n, weight_out[3:0], exp_w);
            end
            n_checks++;
            if (dut_obs !== model_obs()) begin
                n_fail++; $display("FAIL depress_model: got %h expected %h", dut_obs, model_obs());
            end
        end
    endtask

    task automatic test_potentiate_ceiling();
        bit found;
        int exp_w = 0;
        for (int n = 0; n < 17; n++) begin
            seek(1, found);
            n_checks++;
            if (!found) begin
                n_fail++; $display("FAIL potentiate_timeout round %0d: got none expected gate", n);
            end
            exp_w = (exp_w < 15) ? exp_w + 1 : 15;
            n_checks++;
            if (weight_out[3:0] !== 4'(exp_w)) begin
                n_fail++;
                $display("FAIL potentiate_w0 round %0d: got %0d expected %0d", n, weight_out[3:0], exp_w);
            end
            n_checks++;
            if (dut_obs !== model_obs()) begin
                n_fail++; $display("FAIL potentiate_model: got %h expected %h", dut_obs, model_obs());
            end
        end
    endtask

    task automatic test_coincident_pair();
        bit found;
        step(1'b1, 1'b0, 1'b0);
        cur[0] = 255; cur[1] = 0;
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        cur[1] = 255;
        seek(2, found);
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL pair_timeout: got none expected coincidence");
        end
        n_checks++;
        if (weight_out[3:0] !== 4'd8) begin
            n_fail++; $display("FAIL pair_w0: got %0d expected 8", weight_out[3:0]);
        end
        n_checks++;
        if (dut_obs !== model_obs()) begin
            n_fail++; $display("FAIL pair_model: got %h expected %h", dut_obs, model_obs());
        end
    endtask

    task automatic test_learn_freeze();
        logic [N*WW-1:0] snap;
        for (int i = 0; i < N; i++) snap[i*WW +: WW] = WW'(m_w[i]);
        for (int k = 0; k < 40; k++) begin
            cur[0] = $urandom_range(150, 255); cur[1] = $urandom_range(150, 255);
            step(1'b0, 1'b1, 1'b0);
        end
        n_checks++;
        if (weight_out !== snap) begin
            n_fail++; $display("FAIL freeze_weights: got %h expected %h", weight_out, snap);
        end
        n_checks++;
        if (dut_obs !== model_obs()) begin
            n_fail++; $display("FAIL freeze_model: got %h expected %h", dut_obs, model_obs());
        end
    endtask

    task automatic test_hold();
        logic [OW-1:0] snap;
        snap = model_obs();
        for (int k = 0; k < 8; k++) begin
            cur[0] = $urandom_range(0, 255); cur[1] = $urandom_range(0, 255);
            step(1'b0, 1'b0, 1'b1);
            n_checks++;
            if (dut_obs !== snap) begin
                n_fail++; $display("FAIL hold cycle %0d: got %h expected %h", k, dut_obs, snap);
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int k = 0; k < 20; k++) begin
            cur[0] = $urandom_range(100, 255); cur[1] = $urandom_range(100, 255);
            step(1'b0, 1'b1, 1'b1);
        end
        step(1'b1, 1'b1, 1'b1);
        n_checks++;
        if (dut_obs !== {8'h88, 8'h00, 1'b0, 2'b00}) begin
            n_fail++; $display("FAIL mid_reset: got %h expected %h", dut_obs, {8'h88, 11'h000});
        end
    endtask

    task automatic test_random();
        bit r, e, l;
        for (int k = 0; k < 400; k++) begin
            cur[0] = $urandom_range(0, 255); cur[1] = $urandom_range(0, 255);
            r = ($urandom_range(0, 99) == 0);
            e = ($urandom_range(0, 7) != 0);
            l = $urandom_range(0, 1) != 0;
            step(r, e, l);
            n_checks++;
            if (dut_obs !== model_obs()) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %h expected %h", cyc, dut_obs, model_obs());
            end
        end
    endtask

    initial begin
        cur[0] = 0; cur[1] = 0;
        test_reset();
        test_charge();
        test_saturation();
        test_coincident_drive();
        test_depress_floor();
        test_potentiate_ceiling();
        test_coincident_pair();
        test_learn_freeze();
        test_hold();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
